// File: rtl/dmem_pkg.sv
// Shared types and limits for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  localparam int DMEM_LAT_MAX = 15;
  localparam int DMEM_CNT_W   = 4;

endpackage

// File: rtl/dmem_array.sv
// Word-addressed 32-bit storage: one synchronous read/write port, one synchronous
// debug read port, whole array cleared by the asynchronous reset.
module dmem_array #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  output logic [31:0]       dbg_rdata_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;
  logic [31:0] dbg_rdata_q;

  // Read data only moves on an enabled load, so it holds between responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rdata_q     <= '0;
      dbg_rdata_q <= '0;
    end else begin
      if (en_i && we_i) mem_q[addr_i] <= wdata_i;
      if (en_i && !we_i) rdata_q <= mem_q[addr_i];
      dbg_rdata_q <= mem_q[dbg_addr_i];
    end
  end

  assign rdata_o     = rdata_q;
  assign dbg_rdata_o = dbg_rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Handshaked data-memory slave: one request at a time, response after LATENCY
// cycles, misaligned/out-of-range accesses flagged, registered debug read port.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [31:0]       dbg_rdata
);

  localparam logic [DMEM_CNT_W-1:0] LAT_M1 = 4'(LATENCY - 1);

  if (LATENCY < 1 || LATENCY > DMEM_LAT_MAX) begin : g_bad_latency
    $error("dmem_responder: LATENCY must be within 1..15");
  end

  dmem_state_e           state_q;
  logic [DMEM_CNT_W-1:0] cnt_q;
  logic                  req_ready_q;
  logic                  resp_valid_q;
  logic                  resp_err_q;
  logic                  load_hit_q;
  logic                  we_q;
  logic [31:0]           addr_q;
  logic [31:0]           wdata_q;

  logic                  addr_err;
  logic                  access;
  logic [31:0]           arr_rdata;

  assign addr_err = (addr_q[1:0] != 2'b00) || (addr_q[31:ADDR_W+2] != '0);
  assign access   = (state_q == WAIT) && (cnt_q == '0);

  // Counter only decrements while nonzero, so it can never wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      load_hit_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            state_q     <= WAIT;
            cnt_q       <= LAT_M1;
            req_ready_q <= 1'b0;
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= addr_err;
            load_hit_q   <= !addr_err && !we_q;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RESP: begin
          state_q      <= IDLE;
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Request payload is only meaningful once accepted; the FSM state gates its use.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && req_valid) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  dmem_array #(.ADDR_W(ADDR_W)) u_array (
    .clk         (clk),
    .rst         (rst),
    .en_i        (access && !addr_err),
    .we_i        (we_q),
    .addr_i      (addr_q[ADDR_W+1:2]),
    .wdata_i     (wdata_q),
    .rdata_o     (arr_rdata),
    .dbg_addr_i  (dbg_addr),
    .dbg_rdata_o (dbg_rdata)
  );

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = load_hit_q ? arr_rdata : '0;

endmodule
